// File: rtl/babbage_pkg.sv
// babbage_pkg: n/f widths shared with babbage_engine, and the sweep FSM state encoding
package babbage_pkg;
  localparam int BABBAGE_N_W = 6;
  localparam int BABBAGE_F_W = 14;
  typedef enum logic [2:0] {IDLE, ENG_GO, ENG_WAIT, CVT_GO, CVT_WAIT, DWELL, FINISH} sweep_state_t;
endpackage

// File: rtl/babbage_dwell_timer.sv
// babbage_dwell_timer: loadable down-counter with zero flag (dwell hold and watchdog)
module babbage_dwell_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;
  // clear beats load beats count; counting stops at zero
  always_comb cnt_d = clr ? '0 : load ? load_val : (en && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  // counter register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign zero = cnt_q == '0;
endmodule

// File: rtl/babbage_sweep_ctrl.sv
// babbage_sweep_ctrl: sweeps babbage_engine over n_lo..n_hi and feeds each f to bin2bcd; BABBAGE_SWEEP_WATCHDOG_EN adds a wait watchdog
module babbage_sweep_ctrl
  import babbage_pkg::*;
#(
  parameter int N_W            = BABBAGE_N_W,
  parameter int F_W            = BABBAGE_F_W,
  parameter int DWELL_CYCLES   = 50_000_000,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  input  logic [N_W-1:0] n_lo,
  input  logic [N_W-1:0] n_hi,
  output logic           eng_start,
  output logic [N_W-1:0] eng_n,
  input  logic           eng_done,
  input  logic [F_W-1:0] eng_f,
  output logic           cvt_start,
  output logic [F_W-1:0] cvt_bin,
  input  logic           cvt_done,
  output logic [N_W-1:0] cur_n,
  output logic [F_W-1:0] cur_f,
  output logic           busy,
  output logic           sweep_done,
  output logic           err
);
  localparam int DW_W = $clog2(DWELL_CYCLES + 1);
  sweep_state_t   state_q, state_d;
  logic [N_W-1:0] idx_q, idx_d, hi_q, hi_d, cur_n_q, cur_n_d;
  logic [F_W-1:0] cur_f_q, cur_f_d, cvt_bin_q, cvt_bin_d;
  logic           accept, capture, dw_zero, wd_to;
  assign accept  = state_q == IDLE && start && !abort;
  assign capture = state_q == ENG_WAIT && state_d == CVT_GO;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  // next state; abort overrides everything, stray done pulses fall through as no-ops
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start) state_d = n_lo > n_hi ? FINISH : ENG_GO;
      ENG_GO:   state_d = ENG_WAIT;
      ENG_WAIT: state_d = eng_done ? CVT_GO : wd_to ? IDLE : ENG_WAIT;
      CVT_GO:   state_d = CVT_WAIT;
      CVT_WAIT: state_d = cvt_done ? DWELL : wd_to ? IDLE : CVT_WAIT;
      DWELL:    if (dw_zero) state_d = idx_q == hi_q ? FINISH : ENG_GO;
      FINISH:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end
  // idx compared against n_hi before incrementing, so the top code never wraps
  always_comb begin
    idx_d     = (accept && state_d == ENG_GO) ? n_lo : (state_q == DWELL && state_d == ENG_GO) ? idx_q + 1'b1 : idx_q;
    hi_d      = accept ? n_hi : hi_q;
    cur_n_d   = capture ? idx_q : cur_n_q;
    cur_f_d   = capture ? eng_f : cur_f_q;
    cvt_bin_d = capture ? eng_f : cvt_bin_q;
  end
  // datapath registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx_q     <= '0;
      hi_q      <= '0;
      cur_n_q   <= '0;
      cur_f_q   <= '0;
      cvt_bin_q <= '0;
    end else begin
      idx_q     <= idx_d;
      hi_q      <= hi_d;
      cur_n_q   <= cur_n_d;
      cur_f_q   <= cur_f_d;
      cvt_bin_q <= cvt_bin_d;
    end
  babbage_dwell_timer #(.W(DW_W)) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (abort),
    .load     (state_q == CVT_WAIT && state_d == DWELL),
    .en       (state_q == DWELL),
    .load_val (DW_W'(DWELL_CYCLES - 1)),
    .zero     (dw_zero)
  );
`ifdef BABBAGE_SWEEP_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic wd_wait, wd_zero, err_q, err_d;
  assign wd_wait = state_q == ENG_WAIT || state_q == CVT_WAIT;
  assign wd_to   = wd_wait && wd_zero;
  babbage_dwell_timer #(.W(WD_W)) u_wd (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (1'b0),
    .load     (state_d != state_q),
    .en       (wd_wait),
    .load_val (WD_W'(TIMEOUT_CYCLES - 1)),
    .zero     (wd_zero)
  );
  // sticky timeout flag, cleared by the next accepted start
  always_comb err_d = accept ? 1'b0 : wd_to ? 1'b1 : err_q;
  // error flag register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_q <= 1'b0;
    else err_q <= err_d;
  assign err = err_q;
`else
  assign wd_to = 1'b0;
  assign err   = 1'b0;
`endif
  // outputs decoded from state; an abort in FINISH suppresses the completion pulse
  always_comb begin
    eng_start  = state_q == ENG_GO;
    cvt_start  = state_q == CVT_GO;
    busy       = state_q != IDLE;
    sweep_done = state_q == FINISH && !abort;
    eng_n      = idx_q;
    cvt_bin    = cvt_bin_q;
    cur_n      = cur_n_q;
    cur_f      = cur_f_q;
  end
endmodule

// File: tb/tb_babbage_sweep_ctrl.sv
// tb_babbage_sweep_ctrl: randomized sweeps against a transaction-level model with engine/converter stubs
module tb_babbage_sweep_ctrl;
  localparam int DW = 4;
  localparam int TO = 16;
  logic        clk = 0, rst_n = 0, start = 0, abort = 0;
  logic [5:0]  n_lo = 0, n_hi = 0, eng_n, cur_n;
  logic        eng_start, eng_done = 0, cvt_start, cvt_done = 0;
  logic [13:0] eng_f = 0, cvt_bin, cur_f;
  logic        busy, sweep_done, err;
  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  int eng_lat = 3, cvt_lat = 3;
  bit eng_hang = 0;
  int eng_log[$], cvt_log[$];
  int done_cnt = 0, done_cyc = 0, cvt_cnt = 0;
  int eng_done_cyc = -100, cvt_done_cyc = -100, eng_start_cyc = 0, err_cyc = -1;
  int mcur_n = 0, mcur_f = 0;

  babbage_sweep_ctrl #(.N_W(6), .F_W(14), .DWELL_CYCLES(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .n_lo(n_lo), .n_hi(n_hi),
    .eng_start(eng_start), .eng_n(eng_n), .eng_done(eng_done), .eng_f(eng_f),
    .cvt_start(cvt_start), .cvt_bin(cvt_bin), .cvt_done(cvt_done),
    .cur_n(cur_n), .cur_f(cur_f), .busy(busy), .sweep_done(sweep_done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic int fb(int n);
    return (n * n + n + 41) & 16'h3fff;
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // engine stub: f = n^2+n+41 after eng_lat cycles; garbage on eng_f otherwise
  initial begin
    int ecnt, en;
    ecnt = 0;
    en = 0;
    forever begin
      @(posedge clk);
      #1;
      eng_done = 0;
      eng_f = 14'($urandom);
      if (ecnt > 0) begin
        ecnt--;
        if (ecnt == 0 && !eng_hang) begin
          eng_done = 1;
          eng_f = 14'(fb(en));
          eng_done_cyc = cyc;
        end
      end
      if (eng_start) begin
        ecnt = eng_lat;
        en = eng_n;
      end
    end
  end

  // converter stub: done_tick after cvt_lat cycles
  initial begin
    int ccnt;
    ccnt = 0;
    forever begin
      @(posedge clk);
      #1;
      cvt_done = 0;
      if (ccnt > 0) begin
        ccnt--;
        if (ccnt == 0) begin
          cvt_done = 1;
          cvt_done_cyc = cyc;
          cvt_cnt++;
        end
      end
      if (cvt_start) ccnt = cvt_lat;
    end
  end

  // monitor: logs start strobes and completion events
  initial forever begin
    @(posedge clk);
    #1;
    if (eng_start) begin
      eng_log.push_back(int'(eng_n));
      eng_start_cyc = cyc;
    end
    if (cvt_start) begin
      cvt_log.push_back(int'(cvt_bin));
      chk("eng_done_to_cvt_start", cyc - eng_done_cyc, 1);
    end
    if (sweep_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (err && err_cyc < 0) err_cyc = cyc;
  end

  task automatic clear_logs();
    eng_log.delete();
    cvt_log.delete();
    done_cnt = 0;
    cvt_cnt = 0;
  endtask

  task automatic run_sweep(input int lo, input int hi, input bit noisy);
    int exp_n[$];
    int s;
    for (int n = lo; n <= hi; n++) exp_n.push_back(n);
    clear_logs();
    n_lo = 6'(lo);
    n_hi = 6'(hi);
    start = 1;
    s = cyc;
    @(negedge clk);
    start = 0;
    if (noisy) begin
      n_lo = 6'($urandom);
      n_hi = 6'($urandom);
    end
    chk("busy_on_start", busy, 1);
    chk("err_on_start", err, 0);
    for (int i = 0; i < 400 && done_cnt == 0; i++) begin
      start = noisy && i == 3;
      @(negedge clk);
    end
    start = 0;
    chk("busy_at_done", busy, 1);
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    chk("sweep_done_count", done_cnt, 1);
    chk("eng_runs", eng_log.size(), exp_n.size());
    chk("cvt_runs", cvt_log.size(), exp_n.size());
    foreach (exp_n[k]) begin
      if (k < eng_log.size()) chk("eng_n", eng_log[k], exp_n[k]);
      if (k < cvt_log.size()) chk("cvt_bin", cvt_log[k], fb(exp_n[k]));
    end
    if (exp_n.size() > 0) begin
      mcur_n = hi;
      mcur_f = fb(hi);
      chk("cvt_done_to_sweep_done", done_cyc - cvt_done_cyc, DW + 1);
    end else chk("empty_sweep_done_lat", done_cyc - s, 1);
    chk("cur_n", cur_n, mcur_n);
    chk("cur_f", cur_f, mcur_f);
    chk("err_idle", err, 0);
  endtask

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL global_timeout: got running expected finished");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ctl", {eng_start, cvt_start, busy, sweep_done, err}, 0);
    chk("rst_n_vals", {eng_n, cur_n}, 0);
    chk("rst_cvt_bin", cvt_bin, 0);
    chk("rst_cur_f", cur_f, 0);
    rst_n = 1;
    @(negedge clk);
    run_sweep(2, 4, 0);
    run_sweep(5, 5, 0);
    run_sweep(7, 3, 0);
    run_sweep(62, 63, 0);
    // abort during the dwell of n=3 in a 2..6 sweep
    clear_logs();
    n_lo = 2;
    n_hi = 6;
    start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 200 && cvt_cnt < 2; i++) @(negedge clk);
    chk("abort_reach_n3", cvt_cnt, 2);
    @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort_idle", busy, 0);
    repeat (20) @(negedge clk);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_eng_runs", eng_log.size(), 2);
    chk("abort_cur_n", cur_n, 3);
    chk("abort_cur_f", cur_f, fb(3));
    mcur_n = 3;
    mcur_f = fb(3);
    run_sweep(2, 6, 0);
    // abort beats a simultaneous start
    clear_logs();
    n_lo = 1;
    n_hi = 1;
    start = 1;
    abort = 1;
    @(negedge clk);
    start = 0;
    abort = 0;
    chk("abort_start_idle", busy, 0);
    repeat (10) @(negedge clk);
    chk("abort_start_no_eng", eng_log.size(), 0);
    // randomized sweeps with mid-sweep input noise and varied latencies
    for (int t = 0; t < 12; t++) begin
      int lo, hi;
      lo = $urandom_range(0, 63);
      hi = lo + int'($urandom_range(0, 4)) - 1;
      if (hi > 63) hi = 63;
      if (hi < 0) hi = 0;
      eng_lat = $urandom_range(1, 5);
      cvt_lat = $urandom_range(1, 5);
      run_sweep(lo, hi, 1);
    end
    eng_lat = 3;
    cvt_lat = 3;
`ifdef BABBAGE_SWEEP_WATCHDOG_EN
    eng_hang = 1;
    clear_logs();
    err_cyc = -1;
    n_lo = 9;
    n_hi = 9;
    start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 200 && err_cyc < 0; i++) @(negedge clk);
    chk("wd_err", err, 1);
    chk("wd_latency", err_cyc - eng_start_cyc, TO + 1);
    chk("wd_idle", busy, 0);
    chk("wd_no_done", done_cnt, 0);
    eng_hang = 0;
    run_sweep(9, 9, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
